// File: rtl/btn_conditioner_pkg.sv
// Shared types and board defaults for the push-button conditioner.
// The defaults assume a 100 MHz board clock: 5 ms debounce, 250 ms first repeat and 50 ms repeat period.
package btn_conditioner_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2,
    ST_HELD   = 2'd3
  } btn_state_e;

  localparam int N_BTN_DEF         = 6;
  localparam int DEBOUNCE_DEF      = 500000;
  localparam int REPEAT_EN_DEF     = 1;
  localparam int REPEAT_DELAY_DEF  = 25000000;
  localparam int REPEAT_PERIOD_DEF = 5000000;

  // The repeat counter serves both the first delay and the period, so it is sized for the larger of the two.
  function automatic int cnt_w(input int a, input int b);
    return $clog2((a > b) ? a : b);
  endfunction

endpackage

// File: rtl/btn_conditioner_if.sv
// Button bundle between the board pins and the DAC control block.
// master drives the raw buttons; slave is the conditioner.
interface btn_conditioner_if
  import btn_conditioner_pkg::*;
#(
  parameter int N_BTN = N_BTN_DEF
);

  logic [N_BTN-1:0] btn_raw;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] btn_pulse;
  logic             pulse_any;

  modport master (
    output btn_raw,
    input  btn_level,
    input  btn_pulse,
    input  pulse_any
  );

  modport slave (
    input  btn_raw,
    output btn_level,
    output btn_pulse,
    output pulse_any
  );

endinterface

// File: rtl/btn_conditioner_channel.sv
// One button channel: 2-FF synchroniser, debounce filter and press/repeat FSM.
// pulse_nxt is the value pulse takes at the next edge, so the top can register pulse_any in step with it.
module btn_conditioner_channel
  import btn_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF,
  parameter int REPEAT_EN       = REPEAT_EN_DEF,
  parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
  parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic pulse,
  output logic pulse_nxt
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int RW = cnt_w(REPEAT_DELAY, REPEAT_PERIOD);
  localparam logic [DW-1:0] DB_TC = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] RD_TC = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RP_TC = RW'(REPEAT_PERIOD - 1);

  logic [1:0]    sync_q, sync_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          rise, fall;
  logic          rd_tc, rp_tc;
  logic          pulse_set;

  btn_state_e    state_q;
  logic [RW-1:0] rpt_cnt_q;
  logic          pulse_q;

  // Synchroniser and debounce.
  always_comb begin
    sync_d  = {sync_q[0], raw};
    cnt_d   = cnt_q;
    level_d = level_q;
    if (sync_q[1] == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == DB_TC) begin
      level_d = sync_q[1];
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + DW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  // Edges are taken from level_d, so the press pulse lands on the same edge the level rises.
  always_comb begin
    rise      = level_d & ~level_q;
    fall      = ~level_d & level_q;
    rd_tc     = (rpt_cnt_q == RD_TC);
    rp_tc     = (rpt_cnt_q == RP_TC);
    pulse_set = 1'b0;
    // A release beats a coinciding repeat terminal count.
    unique case (state_q)
      ST_IDLE:   pulse_set = rise;
      ST_DELAY:  pulse_set = rd_tc & ~fall;
      ST_REPEAT: pulse_set = rp_tc & ~fall;
      default:   pulse_set = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      rpt_cnt_q <= '0;
      pulse_q   <= 1'b0;
    end else begin
      pulse_q <= pulse_set;
      if (fall) begin
        state_q   <= ST_IDLE;
        rpt_cnt_q <= '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (rise) begin
              rpt_cnt_q <= '0;
              state_q   <= (REPEAT_EN != 0) ? ST_DELAY : ST_HELD;
            end
          end
          ST_DELAY: begin
            if (rd_tc) begin
              rpt_cnt_q <= '0;
              state_q   <= ST_REPEAT;
            end else begin
              rpt_cnt_q <= rpt_cnt_q + RW'(1);
            end
          end
          ST_REPEAT: begin
            if (rp_tc) rpt_cnt_q <= '0;
            else       rpt_cnt_q <= rpt_cnt_q + RW'(1);
          end
          ST_HELD: ;
          default: begin
            state_q   <= ST_IDLE;
            rpt_cnt_q <= '0;
          end
        endcase
      end
    end
  end

  assign level     = level_q;
  assign pulse     = pulse_q;
  assign pulse_nxt = pulse_set;

endmodule

// File: rtl/btn_conditioner.sv
// Push-button conditioner: N_BTN independent channels feeding the DAC inc/dec inputs.
// Simultaneous presses pulse together; the DAC block resolves priority.
module btn_conditioner
  import btn_conditioner_pkg::*;
#(
  parameter int N_BTN           = N_BTN_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF,
  parameter int REPEAT_EN       = REPEAT_EN_DEF,
  parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
  parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
  input  logic               clk,
  input  logic               rst,
  btn_conditioner_if.slave   bus
);

  logic [N_BTN-1:0] level_w;
  logic [N_BTN-1:0] pulse_w;
  logic [N_BTN-1:0] pulse_nxt_w;
  logic             pulse_any_q, pulse_any_d;

  for (genvar gi = 0; gi < N_BTN; gi++) begin : g_ch
    btn_conditioner_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_EN       (REPEAT_EN),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .raw       (bus.btn_raw[gi]),
      .level     (level_w[gi]),
      .pulse     (pulse_w[gi]),
      .pulse_nxt (pulse_nxt_w[gi])
    );
  end

  // OR the next-cycle pulses so pulse_any is high in the same cycle as btn_pulse.
  always_comb pulse_any_d = |pulse_nxt_w;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pulse_any_q <= 1'b0;
    else     pulse_any_q <= pulse_any_d;
  end

  assign bus.btn_level = level_w;
  assign bus.btn_pulse = pulse_w;
  assign bus.pulse_any = pulse_any_q;

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner: a constant vector table, hand-written reset/repeat sequences,
// and random button activity checked every cycle against a timestamp-based reference model.
module tb_btn_conditioner;

  localparam int N  = 6;
  localparam int DC = 4;
  localparam int RD = 8;
  localparam int RP = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  btn_conditioner_if #(.N_BTN(N)) bus();

  btn_conditioner #(
    .N_BTN(N), .DEBOUNCE_CYCLES(DC), .REPEAT_EN(1),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: edges counted from reset release, with the raw value sampled at each edge.
  int         m_edge;
  logic [5:0] m_samp[$];
  logic [5:0] m_lvl, m_pls;
  int         m_chg[N];
  int         m_press[N];

  task automatic model_reset();
    m_edge = 0;
    m_samp.delete();
    m_lvl = '0;
    m_pls = '0;
    for (int c = 0; c < N; c++) begin
      m_chg[c]   = 0;
      m_press[c] = 0;
    end
  endtask

  // The debounce stage at edge x sees the raw value sampled at edge x-2.
  function automatic logic s_at(input int x, input int c);
    if (x < 3) return 1'b0;
    return m_samp[x-3][c];
  endfunction

  task automatic model_edge(input logic [5:0] raw);
    logic [5:0] p;
    bit stable;
    int d;
    m_edge++;
    m_samp.push_back(raw);
    p = '0;
    for (int c = 0; c < N; c++) begin
      stable = 1;
      for (int j = 0; j < DC; j++) begin
        if ((m_edge - j) <= m_chg[c]) stable = 0;
        else if (s_at(m_edge - j, c) == m_lvl[c]) stable = 0;
      end
      if (stable) begin
        m_lvl[c] = ~m_lvl[c];
        m_chg[c] = m_edge;
        if (m_lvl[c]) begin
          m_press[c] = m_edge;
          p[c] = 1'b1;
        end
      end else if (m_lvl[c]) begin
        d = m_edge - m_press[c];
        if (d == RD || (d > RD && ((d - RD) % RP) == 0)) p[c] = 1'b1;
      end
    end
    m_pls = p;
  endtask

  task automatic chk(input string nm, input logic [5:0] act, input logic [5:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Drive raw, advance one edge, and compare against the model on the falling edge.
  task automatic tick(input logic [5:0] raw);
    bus.btn_raw = raw;
    @(posedge clk);
    if (!rst) model_edge(raw);
    @(negedge clk);
    chk("model_level", bus.btn_level, m_lvl);
    chk("model_pulse", bus.btn_pulse, m_pls);
    chk("model_any", {5'b0, bus.pulse_any}, {5'b0, |m_pls});
  endtask

  typedef struct {
    logic [5:0] raw;
    logic [5:0] lvl;
    logic [5:0] pls;
    logic       any;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [5:0] raw, input logic [5:0] lvl,
                     input logic [5:0] pls, input logic any, input int n);
    vec_t v;
    v.raw = raw; v.lvl = lvl; v.pls = pls; v.any = any;
    for (int i = 0; i < n; i++) tbl.push_back(v);
  endtask

  initial begin
    int hold[N];
    logic [5:0] rnd;
    int offs[$];
    int pulses_early;

    bus.btn_raw = '0;
    model_reset();
    @(negedge clk);

    // Reset with every button pressed: outputs stay low, levels rise on the 6th edge after release.
    bus.btn_raw = 6'h3f;
    #1;
    chk("rst_level", bus.btn_level, 6'h00);
    chk("rst_pulse", bus.btn_pulse, 6'h00);
    chk("rst_any", {5'b0, bus.pulse_any}, 6'h00);
    for (int i = 0; i < 3; i++) tick(6'h3f);
    rst = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tick(6'h3f);
      if (i < 6) chk("rst_rel_level_low", bus.btn_level, 6'h00);
      else begin
        chk("rst_rel_level_up", bus.btn_level, 6'h3f);
        chk("rst_rel_pulse", bus.btn_pulse, 6'h3f);
      end
    end
    for (int i = 0; i < 12; i++) tick(6'h00);

    // Clean press with one repeat before release, glitch filtering, then a simultaneous press.
    add(6'h20, 6'h00, 6'h00, 1'b0, 5);
    add(6'h20, 6'h20, 6'h20, 1'b1, 1);
    add(6'h20, 6'h20, 6'h00, 1'b0, 4);
    add(6'h00, 6'h20, 6'h00, 1'b0, 3);
    add(6'h00, 6'h20, 6'h20, 1'b1, 1);
    add(6'h00, 6'h20, 6'h00, 1'b0, 1);
    add(6'h00, 6'h00, 6'h00, 1'b0, 3);
    add(6'h10, 6'h00, 6'h00, 1'b0, 3);
    add(6'h00, 6'h00, 6'h00, 1'b0, 1);
    add(6'h10, 6'h00, 6'h00, 1'b0, 3);
    add(6'h00, 6'h00, 6'h00, 1'b0, 6);
    add(6'h21, 6'h00, 6'h00, 1'b0, 5);
    add(6'h21, 6'h21, 6'h21, 1'b1, 1);
    add(6'h00, 6'h21, 6'h00, 1'b0, 5);
    add(6'h00, 6'h00, 6'h00, 1'b0, 3);
    for (int r = 0; r < tbl.size(); r++) begin
      tick(tbl[r].raw);
      chk($sformatf("tbl%0d_level", r), bus.btn_level, tbl[r].lvl);
      chk($sformatf("tbl%0d_pulse", r), bus.btn_pulse, tbl[r].pls);
      chk($sformatf("tbl%0d_any", r), {5'b0, bus.pulse_any}, {5'b0, tbl[r].any});
    end

    // Auto-repeat: hold bit 3 for 30 cycles and record pulse offsets from the press.
    for (int i = 1; i <= 40; i++) begin
      tick((i <= 30) ? 6'h08 : 6'h00);
      if (bus.btn_pulse[3]) offs.push_back(i);
    end
    chk("rpt_count", 6'(offs.size()), 6'd9);
    for (int k = 0; k < offs.size() && k < 9; k++)
      chk($sformatf("rpt_off%0d", k), 6'(offs[k] - offs[0]),
          6'((k == 0) ? 0 : RD + (k - 1) * RP));

    // Reset while bit 0 is repeating, button still held afterwards.
    for (int i = 0; i < 16; i++) tick(6'h01);
    chk("mid_level_before", bus.btn_level, 6'h01);
    rst = 1'b1;
    model_reset();
    #1;
    chk("mid_rst_level", bus.btn_level, 6'h00);
    chk("mid_rst_pulse", bus.btn_pulse, 6'h00);
    chk("mid_rst_any", {5'b0, bus.pulse_any}, 6'h00);
    tick(6'h01);
    tick(6'h01);
    rst = 1'b0;
    pulses_early = 0;
    for (int i = 1; i <= 6; i++) begin
      tick(6'h01);
      if (i < 6 && bus.btn_pulse[0]) pulses_early++;
    end
    chk("mid_no_early_pulse", 6'(pulses_early), 6'd0);
    chk("mid_repress_pulse", bus.btn_pulse, 6'h01);
    for (int i = 0; i < 10; i++) tick(6'h00);

    // Random activity with per-button hold times long enough to reach repeats.
    rnd = '0;
    for (int c = 0; c < N; c++) hold[c] = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int c = 0; c < N; c++) begin
        if (hold[c] == 0) begin
          rnd[c]  = 1'($urandom_range(0, 1));
          hold[c] = $urandom_range(1, 24);
        end
        hold[c]--;
      end
      tick(rnd);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
